// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter that time-shares one serial pattern detector between two
// bit-stream sources, one FRAME_LEN-bit frame per grant, reporting matches per frame.
module seq_det_arbiter #(
   parameter int                 WIDTH           = 4,
   parameter int                 FRAME_LEN       = 8,
   parameter int                 CNT_W           = 4,
   parameter logic [WIDTH-1:0]   DEFAULT_PATTERN = WIDTH'(4'b1101)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic             x0,
   input  logic             x1,
   input  logic             cfg_we,
   input  logic [WIDTH-1:0] cfg_pattern,
   output logic [1:0]       gnt,
   output logic [WIDTH-1:0] seq,
   output logic             z,
   output logic [CNT_W-1:0] match_cnt,
   output logic             done,
   output logic             done_id
);

   localparam int BCW = (FRAME_LEN < 2) ? 1 : $clog2(FRAME_LEN + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] target;
   logic [BCW-1:0]   bitcnt;
   logic             last;
   logic             pick;
   logic             x_sel;
   logic [WIDTH-1:0] seq_nxt;
   logic             hit;
   logic             last_bit;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      // with both requesting, the source not served last time wins
      pick      = (req == 2'b11) ? ~last : req[1];
      x_sel     = gnt[0] ? x0 : x1;
      seq_nxt   = {seq[WIDTH-2:0], x_sel};
      hit       = (seq_nxt == target);
      last_bit  = (bitcnt == BCW'(FRAME_LEN - 1));
      case (state)
         IDLE:    if (|req) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt       <= '0;
         seq       <= '0;
         z         <= 1'b0;
         match_cnt <= '0;
         done      <= 1'b0;
         done_id   <= 1'b0;
         target    <= DEFAULT_PATTERN;
         bitcnt    <= '0;
         last      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               z <= 1'b0;
               if (cfg_we) target <= cfg_pattern;
               if (|req) begin
                  gnt       <= pick ? 2'b10 : 2'b01;
                  seq       <= '0;
                  match_cnt <= '0;
                  bitcnt    <= '0;
                  last      <= pick;
               end
            end
            RUN: begin
               seq    <= seq_nxt;
               z      <= hit;
               bitcnt <= bitcnt + BCW'(1);
               if (hit && match_cnt != {CNT_W{1'b1}})
                  match_cnt <= match_cnt + CNT_W'(1);
               if (last_bit) begin
                  gnt     <= '0;
                  done    <= 1'b1;
                  done_id <= gnt[1];
               end
            end
            DONE: begin
               done <= 1'b0;
               z    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Scoreboard bench for seq_det_arbiter: a small shift-register model queues the
// expected z/count per bit and the expected end-of-frame report.
module tb_seq_det_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] req = 2'b00;
   logic       x0 = 1'b0, x1 = 1'b0, cfg_we = 1'b0;
   logic [3:0] cfg_pattern = 4'b0000;
   logic [1:0] gnt;
   logic [3:0] seq;
   logic       z, done, done_id;
   logic [3:0] match_cnt;

   logic [1:0] req_s = 2'b00;
   logic       x0_s = 1'b0, x1_s = 1'b0, cfg_we_s = 1'b0;
   logic [3:0] cfg_pattern_s = 4'b0000;
   logic [1:0] gnt_s;
   logic [3:0] seq_s, cnt_s;
   logic       z_s, done_s, done_id_s;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {logic id; logic [3:0] cnt; logic [3:0] sq;} frm_t;
   logic       zq[$];
   logic [3:0] cq[$];
   frm_t       dq[$];

   seq_det_arbiter #(.WIDTH(4), .FRAME_LEN(8), .CNT_W(4), .DEFAULT_PATTERN(4'b1101)) dut (
      .clk(clk), .rst(rst), .req(req), .x0(x0), .x1(x1), .cfg_we(cfg_we),
      .cfg_pattern(cfg_pattern), .gnt(gnt), .seq(seq), .z(z), .match_cnt(match_cnt),
      .done(done), .done_id(done_id));

   seq_det_arbiter #(.WIDTH(4), .FRAME_LEN(20), .CNT_W(4), .DEFAULT_PATTERN(4'b1101)) u_sat (
      .clk(clk), .rst(rst), .req(req_s), .x0(x0_s), .x1(x1_s), .cfg_we(cfg_we_s),
      .cfg_pattern(cfg_pattern_s), .gnt(gnt_s), .seq(seq_s), .z(z_s), .match_cnt(cnt_s),
      .done(done_s), .done_id(done_id_s));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // bits are MSB-first: the first sampled bit is bits[n-1]
   task automatic model_frame(input logic [31:0] bits, input int n, input logic [3:0] tgt,
                              input logic id);
      logic [3:0] m = 4'b0000;
      logic [3:0] c = 4'b0000;
      frm_t r;
      for (int i = 0; i < n; i++) begin
         m = {m[2:0], bits[n-1-i]};
         zq.push_back(m == tgt);
         if (m == tgt && c != 4'hF) c = c + 4'd1;
         cq.push_back(c);
      end
      r.id = id; r.cnt = c; r.sq = m;
      dq.push_back(r);
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 2'b11; req_s = 2'b11;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({gnt, seq, z, match_cnt, done, done_id, gnt_s, z_s, done_s} !== 17'd0) begin
            failures++;
            $display("FAIL reset_outputs cycle%0d: got gnt=%b seq=%b z=%b cnt=%0d done=%b id=%b want all zero",
                     i, gnt, seq, z, match_cnt, done, done_id);
         end
      end
      rst = 1'b0; req_s = 2'b00;
      tick();
      checks++;
      if (gnt !== 2'b01) begin
         failures++;
         $display("FAIL reset_first_grant: got gnt=%b want 01", gnt);
      end
      rst = 1'b1; req = 2'b00;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single();
      logic [31:0] b = 32'b11011010;
      int ngnt = 0;
      logic ez; logic [3:0] ec; frm_t e;
      req = 2'b01;
      tick();
      req = 2'b00;
      if (gnt === 2'b01) ngnt++;
      model_frame(b, 8, 4'b1101, 1'b0);
      for (int i = 0; i < 8; i++) begin
         x0 = b[7-i]; x1 = ~b[7-i];
         tick();
         ez = zq.pop_front(); ec = cq.pop_front();
         checks++;
         if (z !== ez || match_cnt !== ec) begin
            failures++;
            $display("FAIL single_bit%0d: got z=%b cnt=%0d want z=%b cnt=%0d", i+1, z, match_cnt, ez, ec);
         end
         if (gnt === 2'b01) ngnt++;
      end
      checks++;
      if (ngnt != 8) begin
         failures++;
         $display("FAIL single_gnt_len: got %0d cycles want 8", ngnt);
      end
      e = dq.pop_front();
      checks++;
      if (done !== 1'b1 || done_id !== e.id || match_cnt !== e.cnt || seq !== e.sq || gnt !== 2'b00) begin
         failures++;
         $display("FAIL single_done: got done=%b id=%b cnt=%0d seq=%b gnt=%b want 1 %b %0d %b 00",
                  done, done_id, match_cnt, seq, gnt, e.id, e.cnt, e.sq);
      end
      tick();
      checks++;
      if (done !== 1'b0 || z !== 1'b0 || seq !== e.sq || match_cnt !== e.cnt) begin
         failures++;
         $display("FAIL single_after_done: got done=%b z=%b seq=%b cnt=%0d want 0 0 %b %0d",
                  done, z, seq, match_cnt, e.sq, e.cnt);
      end
   endtask

   task automatic test_config();
      logic [31:0] b = 32'b10101000;
      logic ez; logic [3:0] ec; frm_t e;
      cfg_we = 1'b1; cfg_pattern = 4'b1010;
      tick();
      cfg_we = 1'b0; req = 2'b10;
      tick();
      req = 2'b00;
      checks++;
      if (gnt !== 2'b10) begin
         failures++;
         $display("FAIL config_grant: got gnt=%b want 10", gnt);
      end
      model_frame(b, 8, 4'b1010, 1'b1);
      for (int i = 0; i < 8; i++) begin
         x1 = b[7-i]; x0 = ~b[7-i];
         cfg_we = (i == 1); cfg_pattern = 4'b1111;
         tick();
         ez = zq.pop_front(); ec = cq.pop_front();
         checks++;
         if (z !== ez || match_cnt !== ec) begin
            failures++;
            $display("FAIL config_bit%0d: got z=%b cnt=%0d want z=%b cnt=%0d", i+1, z, match_cnt, ez, ec);
         end
      end
      cfg_we = 1'b0;
      e = dq.pop_front();
      checks++;
      if (done !== 1'b1 || done_id !== e.id || match_cnt !== e.cnt || seq !== e.sq) begin
         failures++;
         $display("FAIL config_done: got done=%b id=%b cnt=%0d seq=%b want 1 %b %0d %b",
                  done, done_id, match_cnt, seq, e.id, e.cnt, e.sq);
      end
      tick();
   endtask

   task automatic test_round_robin();
      int tlast = 0;
      logic [31:0] b;
      logic id, ez; logic [3:0] ec; frm_t e;
      req = 2'b11;
      for (int f = 0; f < 3; f++) begin
         tick();
         id = f[0];
         checks++;
         if (gnt !== (id ? 2'b10 : 2'b01) || (f > 0 && cyc - tlast != 10)) begin
            failures++;
            $display("FAIL rr_grant%0d: got gnt=%b spacing=%0d want %b spacing 10",
                     f, gnt, cyc - tlast, id ? 2'b10 : 2'b01);
         end
         tlast = cyc;
         if (f == 2) req = 2'b00;
         b = $urandom;
         model_frame(b, 8, 4'b1010, id);
         for (int i = 0; i < 8; i++) begin
            x0 = id ? ~b[7-i] : b[7-i];
            x1 = id ? b[7-i] : ~b[7-i];
            tick();
            ez = zq.pop_front(); ec = cq.pop_front();
            checks++;
            if (z !== ez || match_cnt !== ec) begin
               failures++;
               $display("FAIL rr_f%0d_bit%0d: got z=%b cnt=%0d want z=%b cnt=%0d", f, i+1, z, match_cnt, ez, ec);
            end
         end
         e = dq.pop_front();
         checks++;
         if (done !== 1'b1 || done_id !== e.id || match_cnt !== e.cnt || seq !== e.sq) begin
            failures++;
            $display("FAIL rr_done%0d: got done=%b id=%b cnt=%0d seq=%b want 1 %b %0d %b",
                     f, done, done_id, match_cnt, seq, e.id, e.cnt, e.sq);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] b = 32'b11011010;
      logic ez; logic [3:0] ec; frm_t e;
      req = 2'b10;
      tick();
      checks++;
      if (gnt !== 2'b10) begin
         failures++;
         $display("FAIL midrst_grant: got gnt=%b want 10", gnt);
      end
      model_frame(32'b111, 3, 4'b1010, 1'b1);
      void'(dq.pop_back());
      for (int i = 0; i < 3; i++) begin
         x1 = 1'b1; x0 = 1'b0;
         tick();
         ez = zq.pop_front(); ec = cq.pop_front();
         checks++;
         if (z !== ez || match_cnt !== ec || done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_bit%0d: got z=%b cnt=%0d done=%b want z=%b cnt=%0d done=0",
                     i+1, z, match_cnt, done, ez, ec);
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({gnt, seq, z, match_cnt, done, done_id} !== 13'd0) begin
         failures++;
         $display("FAIL midrst_outputs: got gnt=%b seq=%b z=%b cnt=%0d done=%b id=%b want all zero",
                  gnt, seq, z, match_cnt, done, done_id);
      end
      tick();
      checks++;
      if (gnt !== 2'b10 || done !== 1'b0) begin
         failures++;
         $display("FAIL midrst_regrant: got gnt=%b done=%b want 10 0", gnt, done);
      end
      req = 2'b00;
      model_frame(b, 8, 4'b1101, 1'b1);
      for (int i = 0; i < 8; i++) begin
         x1 = b[7-i]; x0 = ~b[7-i];
         tick();
         ez = zq.pop_front(); ec = cq.pop_front();
         checks++;
         if (z !== ez || match_cnt !== ec) begin
            failures++;
            $display("FAIL midrst_target_bit%0d: got z=%b cnt=%0d want z=%b cnt=%0d", i+1, z, match_cnt, ez, ec);
         end
      end
      e = dq.pop_front();
      checks++;
      if (done !== 1'b1 || done_id !== e.id || match_cnt !== e.cnt || seq !== e.sq) begin
         failures++;
         $display("FAIL midrst_done: got done=%b id=%b cnt=%0d seq=%b want 1 %b %0d %b",
                  done, done_id, match_cnt, seq, e.id, e.cnt, e.sq);
      end
      tick();
   endtask

   task automatic test_saturation();
      int run = 0, maxrun = 0;
      logic ez; logic [3:0] ec; frm_t e;
      cfg_we_s = 1'b1; cfg_pattern_s = 4'b1111; req_s = 2'b01;
      tick();
      cfg_we_s = 1'b0; req_s = 2'b00;
      checks++;
      if (gnt_s !== 2'b01) begin
         failures++;
         $display("FAIL sat_grant: got gnt=%b want 01", gnt_s);
      end
      model_frame(32'hFFFFF, 20, 4'b1111, 1'b0);
      for (int i = 0; i < 20; i++) begin
         x0_s = 1'b1; x1_s = 1'b0;
         tick();
         ez = zq.pop_front(); ec = cq.pop_front();
         checks++;
         if (z_s !== ez || cnt_s !== ec) begin
            failures++;
            $display("FAIL sat_bit%0d: got z=%b cnt=%0d want z=%b cnt=%0d", i+1, z_s, cnt_s, ez, ec);
         end
         run = (z_s === 1'b1) ? run + 1 : 0;
         if (run > maxrun) maxrun = run;
      end
      checks++;
      if (maxrun != 17) begin
         failures++;
         $display("FAIL sat_z_run: got %0d consecutive want 17", maxrun);
      end
      e = dq.pop_front();
      checks++;
      if (done_s !== 1'b1 || done_id_s !== e.id || cnt_s !== e.cnt || seq_s !== e.sq) begin
         failures++;
         $display("FAIL sat_done: got done=%b id=%b cnt=%0d seq=%b want 1 %b %0d %b",
                  done_s, done_id_s, cnt_s, seq_s, e.id, e.cnt, e.sq);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_config();
      test_round_robin();
      test_reset_mid_frame();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
